axi_10g_ethernet_0_checksum_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one TCP payload checksum engine among `NUM_REQ` AXI-Stream transmit requesters. It sits between the per-connection payload sources and the single TX payload stream that the checksum engine snoops. It grants one fixed-length segment at a time, and only when the checksum FIFO can accept the result. It also records the requester ID of each completed segment in an in-order tag FIFO, so the consumer can pair each checksum with its connection.

---
 rtl/axi_10g_ethernet_0_checksum_arbiter_pkg.sv | 18 +
 rtl/axi_10g_ethernet_0_tag_fifo.sv | 67 ++++++
 rtl/axi_10g_ethernet_0_checksum_arbiter.sv | 142 ++++++++++++++
 tb/tb_axi_10g_ethernet_0_checksum_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_10g_ethernet_0_checksum_arbiter_pkg.sv
// Shared definitions for the checksum arbiter: FSM encoding, engine latency and
// the ID-width helper used by the top and the tag FIFO.
package axi_10g_ethernet_0_checksum_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_WAIT_CSUM = 2'd2
    } arb_state_t;

    localparam int CSUM_ENGINE_LAT = 4;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_tag_fifo.sv
// In-order FIFO of requester IDs; the head entry is held in a register so the
// consumer sees a stable ID one cycle after it was pushed into an empty FIFO.
module axi_10g_ethernet_0_tag_fifo
    import axi_10g_ethernet_0_checksum_arbiter_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = idw(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_next    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    assign count_next = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // The new head is the entry being written when the FIFO drains to it.
            if (count_next != '0) begin
                if (do_push && (rd_next == wr_ptr)) begin
                    dout <= din;
                end else begin
                    dout <= mem[rd_next];
                end
            end
        end
    end

endmodule

// File: rtl/axi_10g_ethernet_0_checksum_arbiter.sv
// Round-robin arbiter that shares one TCP payload checksum engine among NUM_REQ
// AXI-Stream requesters, one fixed-length segment at a time.
module axi_10g_ethernet_0_checksum_arbiter
    import axi_10g_ethernet_0_checksum_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int TCP_DATA_LENGTH = 40,
    parameter int TAG_DEPTH       = 4,
    localparam int IDW            = idw(NUM_REQ)
) (
    input  logic                    s_aclk,
    input  logic                    s_aresetn,
    input  logic [NUM_REQ-1:0]      s_axis_tvalid,
    output logic [NUM_REQ-1:0]      s_axis_tready,
    input  logic [64*NUM_REQ-1:0]   s_axis_tdata,
    input  logic [8*NUM_REQ-1:0]    s_axis_tkeep,
    input  logic [NUM_REQ-1:0]      s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [63:0]             m_axis_tdata,
    output logic [7:0]              m_axis_tkeep,
    output logic                    m_axis_tlast,
    input  logic                    csum_full,
    input  logic                    csum_wr_en,
    input  logic                    tag_rd_en,
    output logic [IDW-1:0]          tag_dout,
    output logic                    tag_empty,
    output logic                    seg_err,
    output logic                    busy
);

    localparam int BEATS = TCP_DATA_LENGTH / 8;
    localparam int CW    = idw(BEATS);

    // Handshakes: a beat moves on m_axis when m_axis_tvalid && m_axis_tready;
    // the granted requester's tready mirrors m_axis_tready, so it moves there too.
    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [IDW-1:0] gnt_q;
    logic [IDW-1:0] last_gnt_q;
    logic [CW-1:0]  beat_q;
    logic           seg_err_q;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           grant_ok;
    logic           m_hs;
    logic           last_beat;
    logic           tag_full;
    logic           tag_push;
    int             idx;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt_q) + k) % NUM_REQ;
            if (!win_found && s_axis_tvalid[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    assign grant_ok  = (state_q == ST_IDLE) && win_found && !csum_full && !tag_full;
    assign last_beat = (beat_q == CW'(BEATS - 1));
    assign m_hs      = (state_q == ST_BUSY) && m_axis_tvalid && m_axis_tready;
    assign tag_push  = m_hs && last_beat;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (grant_ok) state_d = ST_BUSY;
            ST_BUSY:      if (tag_push) state_d = ST_WAIT_CSUM;
            ST_WAIT_CSUM: if (csum_wr_en) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        if (state_q == ST_BUSY) begin
            s_axis_tready[gnt_q] = m_axis_tready;
            m_axis_tvalid        = s_axis_tvalid[gnt_q];
            m_axis_tdata         = s_axis_tdata[{gnt_q, 6'd0} +: 64];
            m_axis_tkeep         = s_axis_tkeep[{gnt_q, 3'd0} +: 8];
            m_axis_tlast         = s_axis_tlast[gnt_q];
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            gnt_q      <= '0;
            last_gnt_q <= IDW'(NUM_REQ - 1);
            beat_q     <= '0;
            seg_err_q  <= 1'b0;
        end else begin
            if (grant_ok) begin
                gnt_q      <= win_id;
                last_gnt_q <= win_id;
            end
            if (m_hs) begin
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
                // Segment length comes from the counter; tlast is only checked.
                if (m_axis_tlast != last_beat) begin
                    seg_err_q <= 1'b1;
                end
            end
        end
    end

    assign seg_err = seg_err_q;
    assign busy    = (state_q != ST_IDLE);

    axi_10g_ethernet_0_tag_fifo #(
        .W     (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (s_aclk),
        .rst_n (s_aresetn),
        .push  (tag_push),
        .din   (gnt_q),
        .pop   (tag_rd_en),
        .dout  (tag_dout),
        .empty (tag_empty),
        .full  (tag_full)
    );

endmodule

// File: tb/tb_axi_10g_ethernet_0_checksum_arbiter.sv
// Randomized bench for the checksum arbiter, checked every cycle against a
// segment-level model built from queues and plain integer bookkeeping.
module tb_axi_10g_ethernet_0_checksum_arbiter;
    import axi_10g_ethernet_0_checksum_arbiter_pkg::*;

    localparam int NUM_REQ         = 2;
    localparam int TCP_DATA_LENGTH = 40;
    localparam int TAG_DEPTH       = 4;
    localparam int BEATS           = TCP_DATA_LENGTH / 8;
    localparam int IDW             = idw(NUM_REQ);
    localparam int VW              = NUM_REQ + 77;

    logic                  s_aclk = 1'b0;
    logic                  s_aresetn;
    logic [NUM_REQ-1:0]    s_axis_tvalid;
    logic [NUM_REQ-1:0]    s_axis_tready;
    logic [64*NUM_REQ-1:0] s_axis_tdata;
    logic [8*NUM_REQ-1:0]  s_axis_tkeep;
    logic [NUM_REQ-1:0]    s_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [63:0]           m_axis_tdata;
    logic [7:0]            m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  csum_full;
    logic                  csum_wr_en;
    logic                  tag_rd_en;
    logic [IDW-1:0]        tag_dout;
    logic                  tag_empty;
    logic                  seg_err;
    logic                  busy;

    always #5 s_aclk = ~s_aclk;

    axi_10g_ethernet_0_checksum_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .TCP_DATA_LENGTH (TCP_DATA_LENGTH),
        .TAG_DEPTH       (TAG_DEPTH)
    ) dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .csum_full     (csum_full),
        .csum_wr_en    (csum_wr_en),
        .tag_rd_en     (tag_rd_en),
        .tag_dout      (tag_dout),
        .tag_empty     (tag_empty),
        .seg_err       (seg_err),
        .busy          (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus knobs (percent probabilities)
    int                 p_valid, p_ready, p_full, p_pop, p_err;
    logic [NUM_REQ-1:0] req_mask;

    // Model: phase 0 = arbitrating, 1 = streaming owner, 2 = awaiting checksum
    int mdl_phase, mdl_owner, mdl_last, mdl_beat, eng_cnt;
    bit mdl_err;
    int tag_q[$];

    function automatic logic [VW-1:0] pack_obs();
        return {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                busy, tag_empty, seg_err};
    endfunction

    task automatic model_reset();
        mdl_phase = 0;
        mdl_owner = 0;
        mdl_last  = NUM_REQ - 1;
        mdl_beat  = 0;
        eng_cnt   = 0;
        mdl_err   = 0;
        tag_q.delete();
    endtask

    task automatic drive();
        int b;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_axis_tvalid[i]         = req_mask[i] && ($urandom_range(0, 99) < p_valid);
            s_axis_tdata[i*64 +: 64] = {$urandom(), $urandom()};
            s_axis_tkeep[i*8 +: 8]   = 8'($urandom());
            b = (mdl_phase == 1 && mdl_owner == i) ? mdl_beat : 0;
            s_axis_tlast[i] = (b == BEATS - 1) ^ ($urandom_range(0, 99) < p_err);
        end
        m_axis_tready = ($urandom_range(0, 99) < p_ready);
        csum_full     = ($urandom_range(0, 99) < p_full);
        tag_rd_en     = ($urandom_range(0, 99) < p_pop);
        csum_wr_en    = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) csum_wr_en = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        logic [NUM_REQ-1:0] e_rdy;
        logic               e_v, e_l;
        logic [63:0]        e_d;
        logic [7:0]         e_k;
        logic [VW-1:0]      exp_v;
        bit                 hs, full_before, found;
        int                 c;
        drive();
        #1;
        e_rdy = '0; e_v = 0; e_d = '0; e_k = '0; e_l = 0;
        if (mdl_phase == 1) begin
            e_rdy[mdl_owner] = m_axis_tready;
            e_v = s_axis_tvalid[mdl_owner];
            e_d = s_axis_tdata[mdl_owner*64 +: 64];
            e_k = s_axis_tkeep[mdl_owner*8 +: 8];
            e_l = s_axis_tlast[mdl_owner];
        end
        exp_v = {e_rdy, e_v, e_d, e_k, e_l, (mdl_phase != 0), (tag_q.size() == 0), mdl_err};
        vectors++;
        assert (pack_obs() === exp_v) else begin
            miscompares++;
            $error("FAIL %s outputs: got %h want %h", tag, pack_obs(), exp_v);
        end
        if (tag_q.size() != 0) begin
            vectors++;
            assert (tag_dout === IDW'(tag_q[0])) else begin
                miscompares++;
                $error("FAIL %s tag_dout: got %0d want %0d", tag, tag_dout, tag_q[0]);
            end
        end
        // Advance the model across the coming clock edge
        hs          = (mdl_phase == 1) && s_axis_tvalid[mdl_owner] && m_axis_tready;
        full_before = (tag_q.size() >= TAG_DEPTH);
        if (tag_rd_en && tag_q.size() > 0) void'(tag_q.pop_front());
        case (mdl_phase)
            0: if (|s_axis_tvalid && !csum_full && !full_before) begin
                found = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (mdl_last + k) % NUM_REQ;
                    if (!found && s_axis_tvalid[c]) begin
                        found = 1;
                        mdl_owner = c;
                    end
                end
                mdl_last  = mdl_owner;
                mdl_phase = 1;
                mdl_beat  = 0;
            end
            1: if (hs) begin
                if (s_axis_tlast[mdl_owner] != (mdl_beat == BEATS - 1)) mdl_err = 1;
                if (mdl_beat == BEATS - 1) begin
                    tag_q.push_back(mdl_owner);
                    mdl_phase = 2;
                    eng_cnt   = CSUM_ENGINE_LAT;
                end else begin
                    mdl_beat++;
                end
            end
            default: if (csum_wr_en) mdl_phase = 0;
        endcase
        @(negedge s_aclk);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic check_reset(input string tag);
        logic [VW-1:0] rst_exp;
        rst_exp = VW'(2);
        vectors++;
        assert (pack_obs() === rst_exp) else begin
            miscompares++;
            $error("FAIL %s outputs: got %h want %h", tag, pack_obs(), rst_exp);
        end
        vectors++;
        assert (tag_dout === '0) else begin
            miscompares++;
            $error("FAIL %s tag_dout: got %0d want 0", tag, tag_dout);
        end
    endtask

    task automatic set_knobs(input logic [NUM_REQ-1:0] m, input int v, input int r,
                             input int f, input int p, input int e);
        req_mask = m; p_valid = v; p_ready = r; p_full = f; p_pop = p; p_err = e;
    endtask

    initial begin
        int guard;
        s_aresetn     = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        csum_full     = 1'b0;
        csum_wr_en    = 1'b0;
        tag_rd_en     = 1'b0;
        set_knobs('0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge s_aclk);
        #1;
        check_reset("reset");
        @(negedge s_aclk);
        s_aresetn = 1'b1;

        // Single requester, always ready
        set_knobs(2'b01, 100, 100, 0, 100, 0);
        run(30, "single");
        // Both requesters continuously valid: alternate grants
        set_knobs(2'b11, 100, 100, 0, 100, 0);
        run(60, "round_robin");
        // Checksum FIFO full holds off grants, then releases
        set_knobs(2'b11, 100, 100, 100, 100, 0);
        run(25, "csum_full");
        set_knobs(2'b11, 100, 100, 0, 100, 0);
        run(20, "csum_release");
        // No pops: tag FIFO fills and blocks further grants, then drains
        set_knobs(2'b11, 100, 100, 0, 0, 0);
        run(90, "tag_fill");
        set_knobs(2'b11, 100, 100, 0, 30, 0);
        run(60, "tag_drain");
        // General random traffic with well-framed segments
        set_knobs(2'b11, 70, 70, 20, 40, 0);
        run(1500, "random");
        // Framing errors: sticky seg_err
        set_knobs(2'b11, 80, 80, 10, 50, 8);
        run(300, "framing");
        set_knobs(2'b11, 80, 80, 10, 50, 0);
        run(100, "sticky");

        // Reset while beat 3 of a segment is pending
        set_knobs(2'b11, 100, 100, 0, 100, 0);
        guard = 0;
        while (!(mdl_phase == 1 && mdl_beat == 3) && guard < 200) begin
            step("seek_beat3");
            guard++;
        end
        vectors++;
        assert (guard < 200) else begin
            miscompares++;
            $error("FAIL seek_beat3 timeout: got %0d cycles want < 200", guard);
        end
        s_aresetn = 1'b0;
        #1;
        check_reset("mid_reset");
        model_reset();
        @(negedge s_aclk);
        s_aresetn = 1'b1;
        run(40, "after_reset");
        set_knobs(2'b11, 60, 75, 15, 45, 0);
        run(600, "random2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
